mem_stage: RTL

//  Memory stage plus MEM/WB pipeline latch. Sits directly downstream of the execute latch and consumes its

---
 rtl/mem_stage.sv | 117 +++++++++++
 1 files changed

// File: rtl/mem_stage.sv
// Memory stage with MEM/WB pipeline latch: runs loads/stores through a dREN/dWEN/dhit
// handshake, stalls upstream until the access completes, and presents writeback data.
module mem_stage #(
    parameter int unsigned DW    = 32,
    parameter int unsigned REGAW = 5
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             mem_en,
    input  logic             flush,
    input  logic [DW-1:0]    ex_aluout,
    input  logic [DW-1:0]    ex_wdat,
    input  logic             ex_dREN,
    input  logic             ex_dWEN,
    input  logic [31:0]      ex_wsel,
    input  logic             ex_reg_wr,
    input  logic             ex_write_sig,
    input  logic             ex_halt,
    output logic             dmemREN,
    output logic             dmemWEN,
    output logic [DW-1:0]    dmemaddr,
    output logic [DW-1:0]    dmemstore,
    input  logic             dhit,
    input  logic [DW-1:0]    dmemload,
    output logic             mem_stall,
    output logic [DW-1:0]    wb_result,
    output logic [REGAW-1:0] wb_wsel,
    output logic             wb_reg_wr,
    output logic             wb_halt
);

    typedef enum logic [1:0] {IDLE, REQ, HALT} state_t;

    state_t            state;
    logic [REGAW-1:0]  wsel_q;
    logic              reg_wr_q;
    logic              write_sig_q;

    logic [REGAW-1:0]  wsel_in;
    logic              mem_op;
    logic              accept;
    logic              unused_wsel_hi;

    assign wsel_in        = ex_wsel[REGAW-1:0];
    assign unused_wsel_hi = ^ex_wsel[31:REGAW];
    assign mem_op         = ex_dREN | ex_dWEN;
    assign accept         = (state == IDLE) && mem_en && !flush;

    // Stall in the capture cycle and while waiting for dhit; reset kills it immediately.
    assign mem_stall = !RST && ((accept && mem_op && !ex_halt) || ((state == REQ) && !dhit));

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state       <= IDLE;
            dmemREN     <= 1'b0;
            dmemWEN     <= 1'b0;
            dmemaddr    <= '0;
            dmemstore   <= '0;
            wsel_q      <= '0;
            reg_wr_q    <= 1'b0;
            write_sig_q <= 1'b0;
            wb_result   <= '0;
            wb_wsel     <= '0;
            wb_reg_wr   <= 1'b0;
            wb_halt     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (flush) begin
                        wb_reg_wr <= 1'b0;
                    end else if (mem_en) begin
                        if (ex_halt) begin
                            wb_result <= ex_aluout;
                            wb_wsel   <= wsel_in;
                            wb_reg_wr <= 1'b0;
                            wb_halt   <= 1'b1;
                            state     <= HALT;
                        end else if (mem_op) begin
                            // A simultaneous read and write request is a store.
                            dmemREN     <= ex_dREN & ~ex_dWEN;
                            dmemWEN     <= ex_dWEN;
                            dmemaddr    <= ex_aluout;
                            dmemstore   <= ex_wdat;
                            wsel_q      <= wsel_in;
                            reg_wr_q    <= ex_reg_wr;
                            write_sig_q <= ex_write_sig;
                            wb_reg_wr   <= 1'b0;
                            state       <= REQ;
                        end else begin
                            wb_result <= ex_aluout;
                            wb_wsel   <= wsel_in;
                            wb_reg_wr <= ex_reg_wr && (wsel_in != '0);
                        end
                    end
                end
                REQ: begin
                    if (dhit) begin
                        dmemREN   <= 1'b0;
                        dmemWEN   <= 1'b0;
                        wb_result <= write_sig_q ? dmemload : dmemaddr;
                        wb_wsel   <= wsel_q;
                        wb_reg_wr <= reg_wr_q && (wsel_q != '0);
                        state     <= IDLE;
                    end
                end
                HALT: begin
                    dmemREN   <= 1'b0;
                    dmemWEN   <= 1'b0;
                    wb_reg_wr <= 1'b0;
                    wb_halt   <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
